// File: rtl/tt_um_counter_gen.sv
// -----------------------------------------------------------------------------
// tt_um_counter_gen
//   Parametrised up/down counter core with a terminal-count pulse and a
//   square-wave blink output that toggles on every wrap.
//
//   Optional feature macro: CNT_PRESCALE_EN
//     defined     -> a PRESCALE_W-bit prescaler gates the count steps, so the
//                    counter steps once every prescale+1 enabled cycles
//     not defined -> the counter steps on every enabled cycle; the prescale
//                    port is present but has no effect
//
// Ports
//   clk       in   1           clock, all state updates on the rising edge
//   rst_n     in   1           asynchronous active-low reset
//   ena       in   1           count enable (low freezes counter and prescaler)
//   clr       in   1           synchronous clear to 0 (highest priority)
//   load      in   1           synchronous load of load_val
//   load_val  in   WIDTH       value taken on load
//   up_dn     in   1           1 = count up, 0 = count down
//   sat       in   1           1 = saturate at the bound, 0 = wrap
//   prescale  in   PRESCALE_W  prescaler divide value (CNT_PRESCALE_EN only)
//   cnt       out  WIDTH       registered count value
//   tc        out  1           registered one-cycle terminal-count pulse
//   blink     out  1           registered, toggles on every wrap event
// -----------------------------------------------------------------------------
module tt_um_counter_gen #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic                  clr,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_val,
   input  logic                  up_dn,
   input  logic                  sat,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [WIDTH-1:0]      cnt,
   output logic                  tc,
   output logic                  blink
);

   localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;
   logic             blink_q, blink_d;
   logic             tick_s;
   logic             step_s;

`ifdef CNT_PRESCALE_EN
   localparam logic [PRESCALE_W-1:0] PRE_ZERO = {PRESCALE_W{1'b0}};
   localparam logic [PRESCALE_W-1:0] PRE_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

   logic [PRESCALE_W-1:0] pre_q, pre_d;

   // Prescaler next state: compares against the live prescale value, so a
   // value lowered below the current count lets it run on and wrap around.
   always_comb begin
      tick_s = (pre_q == prescale);
      pre_d  = pre_q;
      if (clr || load) begin
         pre_d = PRE_ZERO;
      end else if (ena) begin
         pre_d = tick_s ? PRE_ZERO : (pre_q + PRE_ONE);
      end else begin
         pre_d = pre_q;
      end
   end

   // Prescaler register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= PRE_ZERO;
      end else begin
         pre_q <= pre_d;
      end
   end
`else
   // Without the prescaler every enabled cycle is a tick; prescale is folded
   // in only so the port is not left dangling, the OR keeps tick constant.
   assign tick_s = 1'b1 | (&prescale);
`endif

   assign step_s = ena & tick_s & ~clr & ~load;

   // Counter next state: clear beats load beats step; tc defaults low so it
   // can only ever be a single-cycle pulse.
   always_comb begin
      cnt_d   = cnt_q;
      tc_d    = 1'b0;
      blink_d = blink_q;
      if (clr) begin
         cnt_d = CNT_ZERO;
      end else if (load) begin
         cnt_d = load_val;
      end else if (step_s) begin
         if (up_dn) begin
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_ONE;
               // Saturating count landing on the top bound.
               tc_d  = sat && (cnt_q == (CNT_MAX - CNT_ONE));
            end else if (!sat) begin
               cnt_d   = CNT_ZERO;
               tc_d    = 1'b1;
               blink_d = ~blink_q;
            end else begin
               cnt_d = cnt_q;
            end
         end else begin
            if (cnt_q != CNT_ZERO) begin
               cnt_d = cnt_q - CNT_ONE;
               // Saturating count landing on the bottom bound.
               tc_d  = sat && (cnt_q == CNT_ONE);
            end else if (!sat) begin
               cnt_d   = CNT_MAX;
               tc_d    = 1'b1;
               blink_d = ~blink_q;
            end else begin
               cnt_d = cnt_q;
            end
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter, terminal-count and blink registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= CNT_ZERO;
         tc_q    <= 1'b0;
         blink_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         tc_q    <= tc_d;
         blink_q <= blink_d;
      end
   end

   assign cnt   = cnt_q;
   assign tc    = tc_q;
   assign blink = blink_q;

endmodule

// File: tb/tb_tt_um_counter_gen.sv
module tb_tt_um_counter_gen;

   localparam int WIDTH      = 8;
   localparam int PRESCALE_W = 4;
   localparam int MAXV       = (1 << WIDTH) - 1;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  ena, clr, load, up_dn, sat;
   logic [WIDTH-1:0]      load_val;
   logic [PRESCALE_W-1:0] prescale;
   logic [WIDTH-1:0]      cnt;
   logic                  tc, blink;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   tt_um_counter_gen #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .load(load),
      .load_val(load_val), .up_dn(up_dn), .sat(sat), .prescale(prescale),
      .cnt(cnt), .tc(tc), .blink(blink)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef struct packed {
      int   cnt;
      logic tc;
      logic blink;
      int   pre;
   } mstate_t;

   mstate_t m;

   function automatic mstate_t model_next(mstate_t s, logic e, logic c, logic l,
                                          int lv, logic up, logic st, int ps);
      mstate_t n;
      int      target;
      bit      tick;
      n    = s;
      n.tc = 1'b0;
      if (c) begin
         n.cnt = 0;
         n.pre = 0;
      end else if (l) begin
         n.cnt = lv;
         n.pre = 0;
      end else if (e) begin
`ifdef CNT_PRESCALE_EN
         tick  = (s.pre == ps);
         n.pre = tick ? 0 : (s.pre + 1) % (1 << PRESCALE_W);
`else
         tick  = 1'b1;
`endif
         if (tick) begin
            target = s.cnt + (up ? 1 : -1);
            if (target > MAXV || target < 0) begin
               if (!st) begin
                  n.cnt   = (target + MAXV + 1) % (MAXV + 1);
                  n.tc    = 1'b1;
                  n.blink = ~s.blink;
               end
            end else begin
               n.cnt = target;
               n.tc  = st && (target == (up ? MAXV : 0));
            end
         end
      end
      return n;
   endfunction

   // Model state advances on the same edges as the DUT.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m <= '0;
      end else begin
         m <= model_next(m, ena, clr, load, int'(load_val), up_dn, sat, int'(prescale));
      end
   end

   // Compare process: every negedge the DUT must match the model.
   always @(negedge clk) begin
      if (chk_en) begin
         checks += 3;
         if (int'(cnt) != m.cnt) begin
            errors++;
            $display("FAIL model_cnt t=%0t: got %0d expected %0d", $time, cnt, m.cnt);
         end
         if (tc !== m.tc) begin
            errors++;
            $display("FAIL model_tc t=%0t: got %0b expected %0b", $time, tc, m.tc);
         end
         if (blink !== m.blink) begin
            errors++;
            $display("FAIL model_blink t=%0t: got %0b expected %0b", $time, blink, m.blink);
         end
      end
   end

   // ---------------- literal checks ----------------
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one clock: return just after the following negedge.
   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   int tc_seen;

   initial begin
      rst_n = 1'b0; ena = 1'b0; clr = 1'b0; load = 1'b0;
      up_dn = 1'b1; sat = 1'b0; load_val = 8'h00; prescale = 4'd0;
      chk_en = 1'b1;
      cyc(); cyc();
      check("reset_cnt", int'(cnt), 0);
      check("reset_tc", int'(tc), 0);
      check("reset_blink", int'(blink), 0);

      // 256 up-steps with wrap: back to 0, one tc pulse, blink set.
      rst_n = 1'b1; ena = 1'b1; up_dn = 1'b1; sat = 1'b0;
      tc_seen = 0;
      for (int i = 0; i < 256; i++) begin
         cyc();
         tc_seen += int'(tc);
      end
      check("wrap256_cnt", int'(cnt), 0);
      check("wrap256_tc_now", int'(tc), 1);
      check("wrap256_tc_count", tc_seen, 1);
      check("wrap256_blink", int'(blink), 1);

      // Count to 0x37 then assert reset between clock edges.
      for (int i = 0; i < 55; i++) cyc();
      check("pre_reset_cnt", int'(cnt), 8'h37);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_cnt", int'(cnt), 0);
      check("async_reset_tc", int'(tc), 0);
      check("async_reset_blink", int'(blink), 0);
      cyc();
      rst_n = 1'b1;

      // Down saturate: load 2 then 1,0,0,0 with tc only after 1->0.
      up_dn = 1'b0; sat = 1'b1; load = 1'b1; load_val = 8'd2;
      cyc();
      check("sat_load", int'(cnt), 2);
      load = 1'b0;
      cyc(); check("sat_s1_cnt", int'(cnt), 1); check("sat_s1_tc", int'(tc), 0);
      cyc(); check("sat_s2_cnt", int'(cnt), 0); check("sat_s2_tc", int'(tc), 1);
      cyc(); check("sat_s3_cnt", int'(cnt), 0); check("sat_s3_tc", int'(tc), 0);
      cyc(); check("sat_s4_cnt", int'(cnt), 0); check("sat_s4_tc", int'(tc), 0);

      // clr beats load.
      load = 1'b1; load_val = 8'h10;
      cyc();
      check("load_10", int'(cnt), 8'h10);
      clr = 1'b1; load_val = 8'hA5;
      cyc();
      check("clr_wins", int'(cnt), 0);
      clr = 1'b0; load_val = 8'h10;
      cyc();
      load = 1'b0;

      // ena low freezes the count.
      ena = 1'b0; up_dn = 1'b1; sat = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("hold_cnt", int'(cnt), 8'h10);
         check("hold_tc", int'(tc), 0);
      end
      ena = 1'b1;
      cyc();
      check("resume_cnt", int'(cnt), 8'h11);

      // Prescale 3, 12 enabled cycles from a clear.
      clr = 1'b1;
      cyc();
      clr = 1'b0; prescale = 4'd3;
      for (int i = 0; i < 12; i++) cyc();
`ifdef CNT_PRESCALE_EN
      check("prescale_cnt", int'(cnt), 3);
`else
      check("prescale_cnt", int'(cnt), 12);
`endif
      prescale = 4'd0;

      // Down wrap from 0.
      clr = 1'b1;
      cyc();
      clr = 1'b0; up_dn = 1'b0; sat = 1'b0;
      cyc();
      check("dnwrap_cnt", int'(cnt), 8'hFF);
      check("dnwrap_tc", int'(tc), 1);
      check("dnwrap_blink", int'(blink), 1);

      // Up saturate at MAX.
      load = 1'b1; load_val = 8'hFE;
      cyc();
      load = 1'b0; up_dn = 1'b1; sat = 1'b1;
      cyc();
      check("upsat_cnt", int'(cnt), 8'hFF);
      check("upsat_tc", int'(tc), 1);
      cyc();
      check("upsat_hold_cnt", int'(cnt), 8'hFF);
      check("upsat_hold_tc", int'(tc), 0);
      check("upsat_blink", int'(blink), 1);

      // Mixed directed pattern, checked only against the model.
      for (int i = 0; i < 400; i++) begin
         up_dn    = i[5];
         sat      = i[6];
         ena      = (i % 7) != 0;
         clr      = (i % 97) == 50;
         load     = (i % 61) == 30;
         load_val = 8'(i * 37);
         prescale = 4'(i >> 7);
         cyc();
      end

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
